// File: rtl/present_round_engine.sv
// present_round_engine
//   Iterative PRESENT-80 block encryption, one round per clock.
//   Holds the 64-bit cipher state, the 80-bit key schedule register and the
//   5-bit round counter. Each round applies addRoundKey, the 16-way S-box
//   layer and the bit permutation, and advances the key schedule. The last
//   round also applies the final key whitening and presents the ciphertext.
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   valid_i  : plaintext/key present on data_i/key_i
//   ready_o  : engine can accept a block (IDLE only)
//   data_i   : 64-bit plaintext
//   key_i    : 80-bit cipher key
//   valid_o  : data_o holds ciphertext
//   ready_i  : consumer accepts data_o
//   data_o   : 64-bit ciphertext, registered
//   busy_o   : high while rounds are running
module present_round_engine #(
  parameter int unsigned ROUNDS    = 31,
  parameter int unsigned KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [63:0]          data_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [63:0]          data_o,
  output logic                 busy_o
);

  localparam int unsigned STATE_W = 64;
  localparam int unsigned ROUND_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t                 fsm_q;
  logic [STATE_W-1:0]   state_q;
  logic [79:0]          key_q;
  logic [ROUND_W-1:0]   round_q;
  logic [STATE_W-1:0]   data_q;
  logic                 valid_q;
  logic                 ready_q;
  logic                 busy_q;

  // PRESENT 4-bit S-box, shared by the state layer and the key schedule
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Substitution layer: 16 parallel S-boxes over the nibbles
  function automatic logic [63:0] sub_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  // pLayer: bit j moves to (16*j) mod 63; bit 63 is fixed
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      y[(16 * j) % 63] = x[j];
    end
    y[63] = x[63];
    return y;
  endfunction

  logic [63:0] rk_xor;
  logic [63:0] sub_out;
  logic [63:0] perm_out;
  logic [79:0] key_rot;
  logic [79:0] key_next;

  // Round datapath and key schedule for the current round
  always_comb begin
    rk_xor   = state_q ^ key_q[79:16];
    sub_out  = sub_layer(rk_xor);
    perm_out = p_layer(sub_out);
    key_rot  = {key_q[18:0], key_q[79:19]};
    key_next = key_rot;
    key_next[79:76] = sbox(key_rot[79:76]);
    key_next[19:15] = key_rot[19:15] ^ round_q;
  end

  // Control FSM with registered outputs and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (valid_i && ready_q) begin
            state_q <= data_i;
            key_q   <= key_i[79:0];
            round_q <= ROUND_W'(1);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            fsm_q   <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_q <= perm_out;
          key_q   <= key_next;
          round_q <= round_q + ROUND_W'(1);
          // Final whitening uses the freshly scheduled key K32
          if (round_q == ROUND_W'(ROUNDS)) begin
            data_q  <= perm_out ^ key_next[79:16];
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            fsm_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fsm_q   <= S_IDLE;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign busy_o  = busy_q;

endmodule
